aes_state_sel_buf: RTL and testbench
====================================

# aes_state_sel_buf

Registered N-way selector for AES 4x4 byte state matrices with a valid/ready handshake and a 2-entry output buffer. It replaces the plain combinational 2:1 state mux on the round datapath. Round control uses it to pick among the initial state, the round-loop feedback and the bypass/final-round paths. It also decouples the upstream stage from downstream stalls without a combinational ready path.

## Interface
- N_IN, default 4: number of candidate state inputs, legal range 2..16.
- SEL_W, default $clog2(N_IN): width of the select field.
- BYTE_W, default 8: width of one state cell.

- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- in_state, input, [BYTE_W-1:0] x [0:N_IN-1][0:3][0:3]: candidate state matrices.
- in_sel, input, SEL_W: index of the candidate to capture.
- in_valid, input, 1: in_state and in_sel are valid this cycle.
- in_ready, output, 1: block accepts an entry this cycle.
- out_state, output, [BYTE_W-1:0] x [0:3][0:3]: selected state at the buffer head.
- out_sel, output, SEL_W: in_sel value captured with the head entry.
- out_err, output, 1: the head entry was captured with in_sel >= N_IN.
- out_valid, output, 1: the head entry is valid.
- out_ready, input, 1: downstream consumes the head entry this cycle.

## Operation
- **Push:** happens on in_valid & in_ready.
  - Entry stored = {in_state[in_sel], in_sel, err=0}.
  - If in_sel >= N_IN, the entry stored is {in_state[0], in_sel, err=1}, matching the legacy default-to-input-0 behaviour.
- **Pop:** happens on out_valid & out_ready. The head advances to the next entry.
- **Buffer:** 2-entry FIFO with read pointer, write pointer (1 bit each, wrap 1->0) and count (0..2).
- **in_ready:** registered, equals (count < 2) from the previous edge. It has no combinational dependence on out_ready.
  - in_ready is 0 during reset and in the first cycle after reset.
  - It rises in the second cycle after rst deasserts.
- **out_valid:** equals (count != 0).
- **out_state / out_sel / out_err:** driven from the head-entry registers, not from muxed inputs.
- **Simultaneous push and pop:**
  - count 1: count stays 1, the head becomes the new entry, no bubble.
  - count 2: push is impossible because in_ready=0.
  - count 0: only push is possible.
- **Push while in_ready=0:** ignored. Upstream must hold its data.
- **Out-of-order handshake:** none. Order is strict FIFO.
- **Reset mid-operation:** all entries are discarded, count=0, pointers=0.
- **Output reset values:**
  - out_valid=0, out_state=all zeros, out_sel=0, out_err=0, in_ready=0.
- **Hold:** out_state is held stable while out_valid & !out_ready.

## Timing
- Latency: a push at edge k gives out_valid=1 with that entry at edge k+1, provided the buffer was empty.
- Throughput: 1 entry per cycle sustained while out_ready=1.
- Stall: out_ready=0 for 2+ cycles fills the buffer. in_ready then drops one cycle after the second push. No entry is lost and none is duplicated.
- Combinational paths:
  - in_* to out_*: none.
  - out_ready to in_ready: none.
  - All outputs come straight from flops.

## Structure
- Package aes_pkg holds:
  - state_t (4x4 array of byte cells)
  - ROWS=4, COLS=4
  - sel_entry_t struct {state_t state; sel; err}
- Natural sub-module: aes_state_fifo2, a 2-entry registered FIFO of sel_entry_t with push/pop, count and registered not-full.
- The top level holds only the index/range-check selector feeding the FIFO.
- Target size is about 150–250 lines of RTL total.

## Test plan
- **Reset check:** rst high for 3 cycles with in_valid=1.
  - out_valid=0, in_ready=0, out_state all 00 throughout.
  - in_ready=1 on the second cycle after release.
- **Single transfer:** in_state[2] cells = 0x20+idx, in_sel=2, one push, out_ready=1.
  - Next cycle: out_valid=1, out_state[r][c]=0x20+4r+c, out_sel=2, out_err=0.
  - The cycle after: out_valid=0.
- **Back-to-back:** 8 consecutive pushes with in_sel=0,1,2,3,0,1,2,3 and out_ready=1.
  - 8 outputs on consecutive cycles in the same order.
  - in_ready stays 1.
- **Stall and backpressure:** out_ready=0, push A then B.
  - in_ready=0 from the cycle after B.
  - C is held on the inputs.
  - Release out_ready: A, B, C come out in order, no loss and no duplicates.
- **Illegal select (N_IN=3):** in_sel=3 with in_state[0]=0xAA fill.
  - out_state all 0xAA, out_sel=3, out_err=1.
  - The next legal entry has out_err=0.
- **Reset mid-operation:** buffer holding 2 entries, assert rst for 1 cycle.
  - out_valid=0 immediately after the edge.
  - No stale entry appears after release.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types for the AES round-datapath state selector: 4x4 byte state
// matrices and the entry format carried through the selector's output buffer.
package aes_pkg;

  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int CELL_W    = 8;
  localparam int SEL_MAX_W = 4;

  typedef logic [CELL_W-1:0] cell_t;
  typedef cell_t [0:ROWS-1][0:COLS-1] state_t;

  // Default entry layout for the widest selector (16 candidates, 8-bit cells).
  typedef struct packed {
    state_t                 state;
    logic [SEL_MAX_W-1:0]   sel;
    logic                   err;
  } sel_entry_t;

endpackage

// File: rtl/aes_state_fifo2.sv
// Two-entry registered FIFO. Both status flags (not_full, not_empty) are flops,
// so neither side sees a combinational path from the other.
module aes_state_fifo2
  import aes_pkg::*;
#(
  parameter type entry_t = sel_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  entry_t wr_data,
  input  logic   push,
  output logic   not_full,
  output entry_t rd_data,
  output logic   not_empty,
  input  logic   pop
);

  entry_t     mem [0:1];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       do_push;
  logic       do_pop;

  assign do_push = push & not_full;
  assign do_pop  = pop & not_empty;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 2'd1;
    if (do_pop && !do_push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem       <= '{default: '0};
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count_q   <= 2'd0;
      not_full  <= 1'b0;
      not_empty <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count_q   <= count_d;
      // Flags carry the post-edge occupancy; not_full stays low for the
      // first cycle after reset because it only loads here.
      not_full  <= (count_d != 2'd2);
      not_empty <= (count_d != 2'd0);
    end
  end

  // The slot under rd_ptr is never written while it holds a live head entry,
  // so the head stays stable across a downstream stall.
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/aes_state_sel_buf.sv
// Registered N-way selector for AES state matrices feeding a 2-entry buffer.
// An out-of-range select captures candidate 0 and flags the entry with err.
module aes_state_sel_buf
  import aes_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SEL_W  = $clog2(N_IN),
  parameter int BYTE_W = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [0:N_IN-1][0:ROWS-1][0:COLS-1][BYTE_W-1:0] in_state,
  input  logic [SEL_W-1:0]                          in_sel,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  output logic [0:ROWS-1][0:COLS-1][BYTE_W-1:0]     out_state,
  output logic [SEL_W-1:0]                          out_sel,
  output logic                                      out_err,
  output logic                                      out_valid,
  input  logic                                      out_ready
);

  typedef logic [BYTE_W-1:0] byte_t;
  typedef byte_t [0:ROWS-1][0:COLS-1] mat_t;

  typedef struct packed {
    mat_t             state;
    logic [SEL_W-1:0] sel;
    logic             err;
  } entry_t;

  entry_t wr_entry;
  entry_t rd_entry;

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high; valid must not wait on ready, and the source holds its data
  // stable until the transfer occurs.
  always_comb begin
    wr_entry.state = in_state[0];
    wr_entry.sel   = in_sel;
    wr_entry.err   = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      if (int'(in_sel) == i) begin
        wr_entry.state = in_state[i];
        wr_entry.err   = 1'b0;
      end
    end
  end

  aes_state_fifo2 #(
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_data   (wr_entry),
    .push      (in_valid),
    .not_full  (in_ready),
    .rd_data   (rd_entry),
    .not_empty (out_valid),
    .pop       (out_ready)
  );

  assign out_state = rd_entry.state;
  assign out_sel   = rd_entry.sel;
  assign out_err   = rd_entry.err;

endmodule

// File: tb/tb_aes_state_sel_buf.sv
// Bench for aes_state_sel_buf with three candidates, so select value 3 is illegal.
// A queue-based reference model is checked against the DUT on every falling edge.
module tb_aes_state_sel_buf;

  localparam int N = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [0:N-1][0:3][0:3][7:0] in_state;
  logic [1:0]                  in_sel;
  logic                        in_valid;
  logic                        in_ready;
  logic [0:3][0:3][7:0]        out_state;
  logic [1:0]                  out_sel;
  logic                        out_err;
  logic                        out_valid;
  logic                        out_ready;

  aes_state_sel_buf #(.N_IN(N), .SEL_W(2), .BYTE_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_state  (in_state),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_state (out_state),
    .out_sel   (out_sel),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic [130:0] exp_q[$];   // {state, sel, err}, head = next entry out
  logic         m_ready = 1'b0;
  logic         acc = 1'b0;
  logic [1:0]   obs_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [130:0] model_entry(input logic [0:N-1][0:3][0:3][7:0] st,
                                               input logic [1:0] sel);
    logic [127:0] m;
    logic         e;
    m = st[0];
    e = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (int'(sel) == i) begin
        m = st[i];
        e = 1'b0;
      end
    end
    return {m, sel, e};
  endfunction

  // reference model: FIFO of depth 2, ready registered from last occupancy
  always @(posedge clk) begin
    logic do_push;
    logic do_pop;
    if (rst) begin
      exp_q.delete();
      m_ready = 1'b0;
      acc     = 1'b0;
    end else begin
      do_push = in_valid && m_ready;
      do_pop  = (exp_q.size() != 0) && out_ready;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(model_entry(in_state, in_sel));
      acc     = do_push;
      m_ready = (exp_q.size() < 2);
    end
  end

  // scoreboard compare
  always @(negedge clk) begin
    chk("in_ready", in_ready, m_ready);
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("out_state", out_state, exp_q[0][130:3]);
      chk("out_sel", out_sel, exp_q[0][2:1]);
      chk("out_err", out_err, exp_q[0][0]);
    end
    if (out_valid && out_ready) obs_q.push_back(out_sel);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_state();
    for (int s = 0; s < N; s++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          in_state[s][r][c] = 8'($urandom);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (4) step();
  endtask

  logic got;

  initial begin
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    out_ready = 1'b1;
    rand_state();

    // reset held for three edges with in_valid high
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_state", out_state, 128'h0);
      chk("rst_out_sel", out_sel, 2'd0);
      chk("rst_out_err", out_err, 1'b0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", in_ready, 1'b1);

    // single transfer
    step();
    rand_state();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        in_state[2][r][c] = 8'(8'h20 + 4 * r + c);
    in_sel    = 2'd2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("single_valid", out_valid, 1'b1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk("single_cell", out_state[r][c], 8'h20 + 4 * r + c);
    chk("single_sel", out_sel, 2'd2);
    chk("single_err", out_err, 1'b0);
    step();
    @(negedge clk);
    chk("single_gone", out_valid, 1'b0);

    // back-to-back
    step();
    obs_q.delete();
    for (int i = 0; i < 8; i++) begin
      rand_state();
      in_sel   = 2'(i % 4);
      in_valid = 1'b1;
      step();
    end
    drain();
    chk("b2b_count", obs_q.size(), 8);
    for (int i = 0; i < 8 && i < obs_q.size(); i++) chk("b2b_order", obs_q[i], i % 4);

    // stall and backpressure
    obs_q.delete();
    out_ready = 1'b0;
    rand_state(); in_sel = 2'd0; in_valid = 1'b1; step();
    rand_state(); in_sel = 2'd1; step();
    @(negedge clk);
    chk("stall_ready_low", in_ready, 1'b0);
    step();
    rand_state(); in_sel = 2'd2;
    step(); step();
    chk("stall_ready_held", in_ready, 1'b0);
    out_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = acc;
    end
    chk("stall_c_accept", got, 1'b1);
    drain();
    chk("stall_count", obs_q.size(), 3);
    for (int i = 0; i < 3 && i < obs_q.size(); i++) chk("stall_order", obs_q[i], i);

    // illegal select
    rand_state();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        in_state[0][r][c] = 8'hAA;
    in_sel   = 2'd3;
    in_valid = 1'b1;
    step();
    in_sel = 2'd1;
    @(negedge clk);
    chk("illegal_state", out_state, {16{8'hAA}});
    chk("illegal_sel", out_sel, 2'd3);
    chk("illegal_err", out_err, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("legal_after_err", out_err, 1'b0);
    chk("legal_after_sel", out_sel, 2'd1);
    drain();

    // reset mid-operation with two entries held
    out_ready = 1'b0;
    rand_state(); in_sel = 2'd0; in_valid = 1'b1; step();
    rand_state(); in_sel = 2'd2; step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_stale", out_valid, 1'b0);
    end

    // randomized traffic, upstream holds data until accepted
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom_range(0, 3));
        rand_state();
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
